// File: rtl/vedic_mul_pkg.sv
// Shared constants and the requester tag type for the shared multiplier front end.
package vedic_mul_pkg;

    localparam int MUL_LAT = 5;
    localparam int OPW     = 32;
    localparam int PRODW   = 64;
    localparam int ID_W    = 2;

    typedef struct packed {
        logic            v;
        logic [ID_W-1:0] id;
    } tag_t;

endpackage

// File: rtl/vedic_mul_resp_fifo.sv
// Synchronous response FIFO; full/empty from extra-bit pointers, storage not reset.
module vedic_mul_resp_fifo #(
    parameter int WIDTH = 66,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             not_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr, rd_ptr;
    logic             empty, full, do_push, do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

    assign pop_data  = mem[rd_ptr[AW-1:0]];
    assign not_empty = !empty;

endmodule

// File: rtl/vedic_multiplier_32x32_pipelined.sv
// Unsigned DATA_W x DATA_W multiplier built from four half-width vertical/crosswise
// partial products; five register stages, no reset, no stall.
module vedic_multiplier_32x32_pipelined #(
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic [DATA_W-1:0]     a,
    input  logic [DATA_W-1:0]     b,
    output logic [2*DATA_W-1:0]   p
);
    localparam int H = DATA_W / 2;

    logic [2*H-1:0] a_lo, a_hi, b_lo, b_hi;
    logic [2*H-1:0] ll_p1, lh_p1, hl_p1, hh_p1;
    logic [2*H:0]   mid_p2;
    logic [2*H-1:0] ll_p2, hh_p2;
    logic [2*H:0]   lo_p3;
    logic [H:0]     mid_hi_p3;
    logic [2*H-1:0] hh_p3;
    logic [2*H-1:0] hi_sum;
    logic [4*H-1:0] prod_p4, prod_p5;

    assign a_lo = {{H{1'b0}}, a[H-1:0]};
    assign a_hi = {{H{1'b0}}, a[2*H-1:H]};
    assign b_lo = {{H{1'b0}}, b[H-1:0]};
    assign b_hi = {{H{1'b0}}, b[2*H-1:H]};

    // p1: vertical and crosswise half-width products
    always_ff @(posedge clk) begin
        ll_p1 <= a_lo * b_lo;
        lh_p1 <= a_lo * b_hi;
        hl_p1 <= a_hi * b_lo;
        hh_p1 <= a_hi * b_hi;
    end

    // p2: merge the two crosswise terms
    always_ff @(posedge clk) begin
        mid_p2 <= {1'b0, lh_p1} + {1'b0, hl_p1};
        ll_p2  <= ll_p1;
        hh_p2  <= hh_p1;
    end

    // p3: fold the low half of the middle term into the low word
    always_ff @(posedge clk) begin
        lo_p3     <= {1'b0, ll_p2} + {1'b0, mid_p2[H-1:0], {H{1'b0}}};
        mid_hi_p3 <= mid_p2[2*H:H];
        hh_p3     <= hh_p2;
    end

    assign hi_sum = hh_p3 + {{(H-1){1'b0}}, mid_hi_p3} + {{(2*H-1){1'b0}}, lo_p3[2*H]};

    // p4: high word with carries from the low word
    always_ff @(posedge clk) begin
        prod_p4 <= {hi_sum, lo_p3[2*H-1:0]};
    end

    // p5: output register
    always_ff @(posedge clk) begin
        prod_p5 <= prod_p4;
    end

    assign p = prod_p5;

endmodule

// File: rtl/vedic_mul_share_ctrl.sv
// Round-robin, credit-limited front end sharing one pipelined multiplier among NREQ
// requesters; products return in grant order tagged with the requester ID.
module vedic_mul_share_ctrl
    import vedic_mul_pkg::OPW;
    import vedic_mul_pkg::PRODW;
    import vedic_mul_pkg::tag_t;
#(
    parameter int NREQ       = 4,
    parameter int ID_W       = 2,
    parameter int MUL_LAT    = vedic_mul_pkg::MUL_LAT,
    parameter int RESP_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NREQ-1:0]               req_valid,
    input  logic [OPW*NREQ-1:0]           req_a,
    input  logic [OPW*NREQ-1:0]           req_b,
    output logic [NREQ-1:0]               req_ready,
    output logic                          resp_valid,
    input  logic                          resp_ready,
    output logic [ID_W-1:0]               resp_id,
    output logic [PRODW-1:0]              resp_data,
    output logic [$clog2(RESP_DEPTH):0]   inflight,
    output logic                          busy
);
    localparam int CNT_W = $clog2(RESP_DEPTH) + 1;

    logic [ID_W-1:0]  last_grant;
    logic [NREQ-1:0]  grant_oh;
    logic [ID_W-1:0]  grant_id;
    logic             found;
    int               rr_idx;
    logic             can_issue, transfer, pop;
    logic [OPW-1:0]   mul_a, mul_b;
    logic [PRODW-1:0] mul_p;
    tag_t             tag_pipe [MUL_LAT+1];

    assign can_issue = (inflight < CNT_W'(RESP_DEPTH));

    // First valid requester at or after last_grant+1, wrapping.
    always_comb begin
        grant_oh = '0;
        grant_id = '0;
        found    = 1'b0;
        rr_idx   = 0;
        for (int off = 1; off <= NREQ; off++) begin
            rr_idx = (int'(last_grant) + off) % NREQ;
            if (!found && req_valid[rr_idx]) begin
                found            = 1'b1;
                grant_oh[rr_idx] = 1'b1;
                grant_id         = ID_W'(rr_idx);
            end
        end
    end

    assign req_ready = (rst_n && can_issue) ? grant_oh : '0;
    assign transfer  = |(req_valid & req_ready);
    assign pop       = resp_valid && resp_ready;
    assign busy      = (inflight != '0);

    // Control state: pointer, credits, tag valids
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_grant <= ID_W'(NREQ - 1);
            inflight   <= '0;
            for (int k = 0; k <= MUL_LAT; k++) tag_pipe[k].v <= 1'b0;
        end else begin
            if (transfer) last_grant <= grant_id;
            case ({transfer, pop})
                2'b10:   inflight <= inflight + 1'b1;
                2'b01:   inflight <= inflight - 1'b1;
                default: inflight <= inflight;
            endcase
            tag_pipe[0].v <= transfer;
            for (int k = 1; k <= MUL_LAT; k++) tag_pipe[k].v <= tag_pipe[k-1].v;
        end
    end

    // Data path: operands and tag IDs are never reset; the valids mask them.
    always_ff @(posedge clk) begin
        if (transfer) begin
            mul_a <= req_a[int'(grant_id)*OPW +: OPW];
            mul_b <= req_b[int'(grant_id)*OPW +: OPW];
        end
        tag_pipe[0].id <= grant_id;
        for (int k = 1; k <= MUL_LAT; k++) tag_pipe[k].id <= tag_pipe[k-1].id;
    end

    vedic_multiplier_32x32_pipelined #(
        .DATA_W (OPW)
    ) u_mul (
        .clk (clk),
        .a   (mul_a),
        .b   (mul_b),
        .p   (mul_p)
    );

    vedic_mul_resp_fifo #(
        .WIDTH (ID_W + PRODW),
        .DEPTH (RESP_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (tag_pipe[MUL_LAT].v),
        .push_data ({tag_pipe[MUL_LAT].id, mul_p}),
        .pop       (pop),
        .pop_data  ({resp_id, resp_data}),
        .not_empty (resp_valid)
    );

endmodule

// File: tb/tb_vedic_mul_share_ctrl.sv
// Scoreboard bench for vedic_mul_share_ctrl: directed issue sequences push expected
// responses; an independent monitor pops and compares every delivered response.
module tb_vedic_mul_share_ctrl;

    localparam int NREQ = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [32*NREQ-1:0] req_a, req_b;
    logic [NREQ-1:0]   req_ready;
    logic              resp_valid;
    logic              resp_ready;
    logic [1:0]        resp_id;
    logic [63:0]       resp_data;
    logic [3:0]        inflight;
    logic              busy;

    logic [31:0] a_v [NREQ];
    logic [31:0] b_v [NREQ];

    typedef struct {
        logic [1:0]  id;
        logic [63:0] prod;
        int          t;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            req_a[32*i +: 32] = a_v[i];
            req_b[32*i +: 32] = b_v[i];
        end
    end

    vedic_mul_share_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_data  (resp_data),
        .inflight   (inflight),
        .busy       (busy)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor: every accepted response must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n && resp_valid && resp_ready) begin
            if (sb.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_resp actual id=%0d data=%h required none (cycle %0d)",
                         resp_id, resp_data, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("resp_id", 64'(resp_id), 64'(e.id));
                chk("resp_data", resp_data, e.prod);
                if (e.t != 0) chk("resp_latency", 64'(cyc), 64'(e.t));
            end
        end
    end

    // Drive one cycle of requests from the posedge+1 phase, check the grant at
    // the negedge, and record the expected response of each granted requester.
    task automatic issue_cycle(input logic [3:0] vld, input logic [3:0] exp_rdy,
                               input bit timed, input bit record);
        req_valid = vld;
        @(negedge clk);
        chk("req_ready", 64'(req_ready), 64'(exp_rdy));
        if (record) begin
            for (int i = 0; i < NREQ; i++) begin
                if (exp_rdy[i]) begin
                    exp_t e;
                    e.id   = 2'(i);
                    e.prod = {32'd0, a_v[i]} * {32'd0, b_v[i]};
                    e.t    = timed ? cyc + 7 : 0;
                    sb.push_back(e);
                end
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic wait_idle(input string name);
        for (int k = 0; k < 300; k++) begin
            if (!busy && sb.size() == 0) break;
            @(posedge clk); #1;
        end
        chk({name, "_busy"}, 64'(busy), 64'd0);
        chk({name, "_sb_empty"}, 64'(sb.size()), 64'd0);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen;
        rst_n      = 1'b0;
        req_valid  = '0;
        resp_ready = 1'b1;
        for (int i = 0; i < NREQ; i++) begin a_v[i] = '0; b_v[i] = '0; end
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_inflight", 64'(inflight), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // 1: single op 3*5 from requester 0, exact 6-edge latency
        a_v[0] = 32'd3; b_v[0] = 32'd5;
        issue_cycle(4'b0001, 4'b0001, 1'b1, 1'b1);
        req_valid = '0;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            chk("t1_resp_valid", 64'(resp_valid), 64'(k == 7));
            if (k == 1) chk("t1_inflight", 64'(inflight), 64'd1);
            if (k == 7) begin
                chk("t1_resp_id", 64'(resp_id), 64'd0);
                chk("t1_resp_data", resp_data, 64'd15);
            end
        end
        @(posedge clk); #1;
        wait_idle("t1");

        // 2: requester 2, max operands then 2^16 * 2^16, back to back
        a_v[2] = 32'hFFFF_FFFF; b_v[2] = 32'hFFFF_FFFF;
        issue_cycle(4'b0100, 4'b0100, 1'b1, 1'b0);
        sb.push_back('{id: 2'd2, prod: 64'hFFFF_FFFE_0000_0001, t: cyc + 6});
        a_v[2] = 32'h0001_0000; b_v[2] = 32'h0001_0000;
        issue_cycle(4'b0100, 4'b0100, 1'b1, 1'b0);
        sb.push_back('{id: 2'd2, prod: 64'h0000_0001_0000_0000, t: cyc + 6});
        req_valid = '0;
        wait_idle("t2");

        // 3: all requesters contend, RR order from requester 0, no bubbles
        apply_reset();
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                a_v[i] = 32'hF000_0000 + 32'(i * 7 + k);
                b_v[i] = 32'h1234_5678 ^ 32'(k << (i * 4));
            end
            issue_cycle(4'b1111, 4'(1 << (k % 4)), 1'b1, 1'b1);
        end
        req_valid = '0;
        wait_idle("t3");

        // 4: consumer stalled, credits cap issue at RESP_DEPTH
        resp_ready = 1'b0;
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                a_v[i] = 32'(100 + i + k);
                b_v[i] = 32'(1000 * (k + 1) + i);
            end
            issue_cycle(4'b1111, 4'(1 << (k % 4)), 1'b0, 1'b1);
        end
        for (int k = 0; k < 10; k++) issue_cycle(4'b1111, 4'b0000, 1'b0, 1'b1);
        @(negedge clk);
        chk("t4_inflight_full", 64'(inflight), 64'd8);
        chk("t4_resp_valid_held", 64'(resp_valid), 64'd1);
        @(posedge clk); #1;
        resp_ready = 1'b1;
        issue_cycle(4'b1111, 4'b0000, 1'b0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            a_v[k] = 32'hDEAD_0000 + 32'(k);
            issue_cycle(4'b1111, 4'(1 << k), 1'b0, 1'b1);
        end
        req_valid = '0;
        wait_idle("t4");

        // 5: reset with ops in flight discards them and restores priority
        for (int i = 0; i < NREQ; i++) begin a_v[i] = 32'(7 + i); b_v[i] = 32'(9 + i); end
        issue_cycle(4'b0111, 4'b0001, 1'b0, 1'b0);
        issue_cycle(4'b0111, 4'b0010, 1'b0, 1'b0);
        issue_cycle(4'b0111, 4'b0100, 1'b0, 1'b0);
        req_valid = '0;
        repeat (2) begin @(posedge clk); #1; end
        apply_reset();
        @(negedge clk);
        chk("t5_inflight", 64'(inflight), 64'd0);
        chk("t5_busy", 64'(busy), 64'd0);
        seen = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            seen = seen | resp_valid;
        end
        chk("t5_no_stale_resp", 64'(seen), 64'd0);
        @(posedge clk); #1;
        issue_cycle(4'b1111, 4'b0001, 1'b1, 1'b1);
        req_valid = '0;
        wait_idle("t5");

        // 6: requester 3 joins a requester-1 burst; idle cycles keep the pointer
        a_v[1] = 32'h0000_ABCD; b_v[1] = 32'h0000_1111;
        a_v[3] = 32'h8000_0000; b_v[3] = 32'h0000_0003;
        issue_cycle(4'b0010, 4'b0010, 1'b1, 1'b1);
        issue_cycle(4'b1010, 4'b1000, 1'b1, 1'b1);
        issue_cycle(4'b1010, 4'b0010, 1'b1, 1'b1);
        issue_cycle(4'b1010, 4'b1000, 1'b1, 1'b1);
        for (int k = 0; k < 3; k++) issue_cycle(4'b0000, 4'b0000, 1'b1, 1'b1);
        issue_cycle(4'b1010, 4'b0010, 1'b1, 1'b1);
        req_valid = '0;
        wait_idle("t6");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/vedic_mul_share_ctrl.md
Name: vedic_mul_share_ctrl

Overview:
Arbitrated front end that shares one vedic_multiplier_32x32_pipelined instance among NREQ requesters. Round-robin grants at most one operand pair per cycle. Each product is tagged with its requester ID through the fixed-latency, non-stallable multiplier pipeline. Results land in a response FIFO, and credit-based issue ensures no in-flight result is ever dropped.

Parameters:
NREQ, 4, number of requesters (2..8)
ID_W, 2, requester ID width, equal to clog2(NREQ)
MUL_LAT, 5, clock edges from operand register load to a valid multiplier result (fixed by the multiplier)
RESP_DEPTH, 8, response FIFO entries; also the maximum outstanding operations (power of 2)

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
req_valid  in  NREQ  per-requester operand valid
req_a  in  32*NREQ  packed multiplicands; slice i = [32*i+31:32*i]
req_b  in  32*NREQ  packed multipliers, same packing as req_a
req_ready  out  NREQ  one-hot grant; a transfer occurs when req_valid[i] and req_ready[i] are both high
resp_valid  out  1  FIFO head valid
resp_ready  in  1  consumer accepts head
resp_id  out  ID_W  requester ID of head entry
resp_data  out  64  unsigned product of head entry
inflight  out  clog2(RESP_DEPTH)+1  outstanding count (pipeline plus FIFO)
busy  out  1  inflight != 0

Behaviour:
Clock and reset:
- Single clock domain.
- rst_n is sampled on the rising edge of clk and is active low.
Reset state:
- resp_valid=0, inflight=0, busy=0, req_ready=0.
- All tag-pipe valids and FIFO pointers cleared.
- Round-robin pointer set so requester 0 has top priority.
Issue rule:
- can_issue = (inflight < RESP_DEPTH).
- req_ready is the one-hot RR winner among req_valid, gated by can_issue. It is combinational from req_valid and registered state.
- Requesters hold valid and operands until ready. Dropping valid before ready is legal (no transfer).
Arbitration:
- Priority starts at last_grant+1 and wraps modulo NREQ.
- last_grant updates only on a transfer.
- Idle cycles do not move the pointer.
Operand and tag pipeline:
- On a transfer at edge t: mul_a/mul_b registers load the winner's operands, and tag_pipe[0] loads {1, id}.
- On non-transfer edges, tag_pipe[0].v is cleared; the operand registers may hold their old value.
- tag_pipe[k] <= tag_pipe[k-1] for k = 1..MUL_LAT.
- tag_pipe[MUL_LAT] aligns with the multiplier output after edge t+MUL_LAT.
Response capture:
- When tag_pipe[MUL_LAT].v=1, {id, result} is pushed into the FIFO at edge t+MUL_LAT+1.
- resp_valid rises after that edge, so acceptance-to-resp_valid latency is 6 edges at the default MUL_LAT.
- The push can never find the FIFO full, because the credit invariant guarantees a slot.
Output order:
- Responses appear in grant order (in-order pipeline, FIFO order).
Throughput:
- One issue per cycle sustained while resp_ready=1 and inflight < RESP_DEPTH.
Credit accounting:
- inflight increments on a transfer and decrements on a pop (resp_valid & resp_ready).
- A simultaneous transfer and pop leaves inflight unchanged.
- A credit freed by a pop is usable on the following cycle, because can_issue uses registered inflight.
FIFO:
- Full/empty are tracked by extra-bit pointers.
- Pop when empty is ignored.
- resp_id/resp_data hold while resp_valid=1 and resp_ready=0.
Reset mid-operation:
- All in-flight operations and FIFO contents are discarded; no response is ever produced for them.
- The multiplier has no reset. Its stale contents are masked by the cleared tag valids.
Arithmetic:
- Unsigned 32x32 -> 64, no truncation.

Decomposition:
- Package vedic_mul_pkg holds: MUL_LAT=5, OPW=32, PRODW=64, and typedef tag_t {logic v; logic [ID_W-1:0] id}.
- Natural sub-module: vedic_mul_resp_fifo (synchronous FIFO, width ID_W+64, depth RESP_DEPTH).
- Round-robin logic stays inline.

Test Plan:
1. Reset, then req_valid=0001 with a=3, b=5 held one cycle, resp_ready=1 -> req_ready=0001 same cycle. After 6 edges: resp_valid=1, resp_id=0, resp_data=15.
2. Requester 2 with a=b=0xFFFFFFFF, then a=0x00010000, b=0x00010000 -> resp_data 0xFFFFFFFE00000001 then 0x0000000100000000, both resp_id=2, in order, on consecutive cycles.
3. All four req_valid held high, distinct operands, resp_ready=1 -> grants in order 0,1,2,3,0,... one per cycle with no bubbles. Responses carry matching IDs and products, 6 cycles after each grant.
4. resp_ready=0, req_valid=1111 continuous -> exactly 8 transfers, then req_ready=0 and inflight=8. FIFO later holds 8 entries with no loss. Raising resp_ready then drains 8 results in grant order, and issue resumes one cycle after the first pop.
5. Issue 3 ops, then assert rst_n=0 for one cycle 2 edges later -> no resp_valid ever seen for those ops, inflight=0. The next request after reset is granted to requester 0 first.
6. Requester 1 alone, valid held 4 cycles while requester 3 rises mid-burst -> grants alternate 1,3,1,3. The pointer does not advance on idle cycles.
